// File: rtl/ternary_array_sequencer.sv
// rtl/ternary_array_sequencer.sv - weight-load / stream / drain sequencer for a ternary systolic array
module ternary_array_sequencer #(
  parameter int ARRAY_SIZE = 64,
  parameter int PIPE_LAT   = 2*ARRAY_SIZE-1,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          reuse_weights,
  input  logic [CNT_W-1:0]              num_vectors,
  input  logic                          abort,
  output logic                          wmem_req,
  output logic [$clog2(ARRAY_SIZE)-1:0] wmem_addr,
  input  logic                          wmem_rvalid,
  output logic                          array_weight_load,
  output logic [$clog2(ARRAY_SIZE)-1:0] array_weight_row,
  output logic                          array_enable,
  input  logic                          act_avail,
  output logic                          act_pop,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          done
);
  localparam int AW = $clog2(ARRAY_SIZE);
  localparam logic [AW:0]      ROWS     = (AW+1)'(ARRAY_SIZE);
  localparam logic [AW-1:0]    LAST_ROW = AW'(ARRAY_SIZE-1);
  localparam logic [CNT_W+1:0] LAT      = (CNT_W+2)'(PIPE_LAT);

  typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [CNT_W:0]   num_lat;
  logic [AW:0]      req_cnt;
  logic [AW-1:0]    rsp_cnt;
  logic [CNT_W:0]   issued;
  logic [CNT_W:0]   out_cnt;
  logic [CNT_W+1:0] en_cnt;
  logic             stream_ok;

  // An abort cycle already belongs to the cancelled job, so every strobe is suppressed in it.
  assign stream_ok         = (state == S_STREAM) && (issued < num_lat) && act_avail && !abort;
  assign wmem_req          = (state == S_WLOAD) && (req_cnt < ROWS) && !abort;
  assign wmem_addr         = req_cnt[AW-1:0];
  assign array_weight_load = (state == S_WLOAD) && wmem_rvalid && !abort;
  assign array_weight_row  = rsp_cnt;
  assign act_pop           = stream_ok;
  assign array_enable      = stream_ok || ((state == S_DRAIN) && !abort);
  assign out_valid         = array_enable && (en_cnt >= LAT);
  assign busy              = (state != S_IDLE);
  assign done              = (state == S_DONE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      num_lat <= '0;
      req_cnt <= '0;
      rsp_cnt <= '0;
      issued  <= '0;
      out_cnt <= '0;
      en_cnt  <= '0;
    end else if (state != S_IDLE && abort) begin
      state   <= S_IDLE;
      num_lat <= '0;
      req_cnt <= '0;
      rsp_cnt <= '0;
      issued  <= '0;
      out_cnt <= '0;
      en_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            num_lat <= {1'b0, num_vectors};
            req_cnt <= '0;
            rsp_cnt <= '0;
            issued  <= '0;
            out_cnt <= '0;
            en_cnt  <= '0;
            state   <= reuse_weights ? S_STREAM : S_WLOAD;
          end
        end
        S_WLOAD: begin
          if (wmem_req) req_cnt <= req_cnt + 1'b1;
          if (array_weight_load) begin
            if (rsp_cnt == LAST_ROW) begin
              rsp_cnt <= '0;
              req_cnt <= '0;
              state   <= (num_lat != '0) ? S_STREAM : S_DONE;
            end else begin
              rsp_cnt <= rsp_cnt + 1'b1;
            end
          end
        end
        S_STREAM: begin
          // A reused-weight job with zero vectors has nothing to stream or drain.
          if (num_lat == '0) state <= S_DONE;
          if (act_pop) begin
            issued <= issued + 1'b1;
            if (issued + 1'b1 == num_lat) state <= S_DRAIN;
          end
        end
        S_DRAIN: ;
        S_DONE: begin
          state   <= S_IDLE;
          num_lat <= '0;
          issued  <= '0;
          out_cnt <= '0;
          en_cnt  <= '0;
        end
        default: state <= S_IDLE;
      endcase

      if (array_enable) en_cnt <= en_cnt + 1'b1;
      if (out_valid) begin
        out_cnt <= out_cnt + 1'b1;
        if (out_cnt + 1'b1 == num_lat) state <= S_DONE;
      end
    end
  end
endmodule

// File: tb/tb_ternary_array_sequencer.sv
// tb/tb_ternary_array_sequencer.sv - randomized scoreboard bench for ternary_array_sequencer
module tb_ternary_array_sequencer;
  localparam int N   = 64;
  localparam int LAT = 2*N-1;
  localparam int CW  = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, reuse_weights = 1'b0, abort = 1'b0;
  logic wmem_rvalid = 1'b0, act_avail = 1'b0;
  logic [CW-1:0] num_vectors = '0;
  logic wmem_req, array_weight_load, array_enable, act_pop, out_valid, busy, done;
  logic [5:0] wmem_addr, array_weight_row;

  int checks = 0, failures = 0;
  int q_addr[$], q_row[$], q_out[$], q_num[$], q_reuse[$];
  int reqs_seen = 0, pops_seen = 0, outs_seen = 0, en_seen = 0, done_cnt = 0;
  bit post_done = 1'b0, pend_req = 1'b0;
  int avail_mode = 0, tog = 0;

  ternary_array_sequencer #(.ARRAY_SIZE(N), .PIPE_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_weights(reuse_weights),
    .num_vectors(num_vectors), .abort(abort), .wmem_req(wmem_req), .wmem_addr(wmem_addr),
    .wmem_rvalid(wmem_rvalid), .array_weight_load(array_weight_load),
    .array_weight_row(array_weight_row), .array_enable(array_enable), .act_avail(act_avail),
    .act_pop(act_pop), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic void flush_job();
    q_addr.delete(); q_row.delete(); q_out.delete(); q_num.delete(); q_reuse.delete();
    reqs_seen = 0; pops_seen = 0; outs_seen = 0; en_seen = 0; post_done = 1'b0;
  endfunction

  // Weight memory: data valid exactly one cycle after each request.
  initial forever begin
    @(negedge clk);
    pend_req = wmem_req;
    @(posedge clk);
    #1 wmem_rvalid = rst_n ? pend_req : 1'b0;
  end

  // Activation FIFO occupancy: always, alternating, or random.
  initial forever begin
    @(posedge clk);
    #1;
    tog++;
    case (avail_mode)
      0:       act_avail = 1'b1;
      1:       act_avail = (tog % 2 == 0);
      default: act_avail = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops expectations whenever the DUT presents a strobe.
  initial begin
    int n, r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (post_done) begin
          chk("idle_after_done_busy", busy, 0);
          chk("done_single_cycle", done, 0);
          post_done = 1'b0;
        end
        if (wmem_req) begin
          reqs_seen++;
          if (q_addr.size() == 0) chk("unexpected_wmem_req", 1, 0);
          else chk("wmem_addr", wmem_addr, q_addr.pop_front());
        end
        if (array_weight_load) begin
          if (q_row.size() == 0) chk("unexpected_weight_load", 1, 0);
          else chk("array_weight_row", array_weight_row, q_row.pop_front());
        end
        if (act_pop) begin
          pops_seen++;
          chk("pop_without_avail", act_avail, 1);
        end
        if (out_valid) begin
          outs_seen++;
          if (!array_enable) chk("out_valid_without_enable", 1, 0);
          else if (q_out.size() == 0) chk("unexpected_out_valid", 1, 0);
          else chk("out_valid_enabled_index", en_seen, q_out.pop_front());
        end
        if (array_enable) en_seen++;
        if (done) begin
          if (q_num.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            n = q_num.pop_front();
            r = q_reuse.pop_front();
            chk("job_pops", pops_seen, n);
            chk("job_outputs", outs_seen, n);
            chk("job_enabled_cycles", en_seen, (n == 0) ? 0 : n + LAT);
            chk("job_wmem_reqs", reqs_seen, (r != 0) ? 0 : N);
            chk("job_rows_drained", q_row.size(), 0);
          end
          reqs_seen = 0; pops_seen = 0; outs_seen = 0; en_seen = 0;
          done_cnt++;
          post_done = 1'b1;
        end
      end
    end
  end

  task automatic issue_start(input int num, input bit reuse);
    @(posedge clk);
    #1;
    start = 1'b1; reuse_weights = reuse; num_vectors = CW'(num);
    @(posedge clk);
    #1;
    start = 1'b0; reuse_weights = 1'($urandom_range(0, 1)); num_vectors = CW'($urandom_range(0, 9));
  endtask

  task automatic run_job(input int num, input bit reuse, input int mode, input bit poke);
    int target;
    if (!reuse) for (int i = 0; i < N; i++) begin q_addr.push_back(i); q_row.push_back(i); end
    for (int i = 0; i < num; i++) q_out.push_back(LAT + i);
    q_num.push_back(num);
    q_reuse.push_back(int'(reuse));
    target = done_cnt + 1;
    avail_mode = mode;
    issue_start(num, reuse);
    @(negedge clk);
    if (!reuse) chk("first_wload_cycle_req", wmem_req, 1);
    else if (mode == 0 && num > 0) chk("first_stream_cycle_pop", {array_enable, act_pop}, 2'b11);
    if (poke) begin
      repeat (8) @(posedge clk);
      issue_start(9, 1'b1);
    end
    for (int c = 0; c < 4000 && done_cnt < target; c++) @(posedge clk);
    chk("job_done_within_budget", done_cnt >= target, 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int found;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero",
        {busy, done, wmem_req, array_weight_load, array_enable, act_pop, out_valid, wmem_addr, array_weight_row}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_not_busy", busy, 0);

    run_job(3, 1'b0, 0, 1'b0);
    run_job(1, 1'b1, 0, 1'b0);
    run_job(0, 1'b0, 0, 1'b0);
    run_job(4, 1'b1, 1, 1'b0);
    run_job(5, 1'b0, 2, 1'b1);

    // Abort while loading: cancel in the cycle where row 20 would load.
    for (int i = 0; i < N; i++) begin q_addr.push_back(i); q_row.push_back(i); end
    avail_mode = 0;
    issue_start(2, 1'b0);
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (array_weight_load && array_weight_row == 6'd19) found = 1;
    end
    chk("abort_reached_row19", found, 1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_then_idle", {busy, done, wmem_req}, 0);
    @(posedge clk);
    #1 flush_job();
    run_job(2, 1'b0, 0, 1'b0);

    // Reset while draining.
    for (int i = 0; i < 3; i++) q_out.push_back(LAT + i);
    q_num.push_back(3); q_reuse.push_back(1);
    avail_mode = 0;
    issue_start(3, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("draining_enable_busy", {busy, array_enable, act_pop}, 3'b110);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_in_drain_outputs_zero",
        {busy, done, wmem_req, array_weight_load, array_enable, act_pop, out_valid, wmem_addr, array_weight_row}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    flush_job();
    @(negedge clk);
    chk("after_reset_idle", busy, 0);
    run_job(3, 1'b0, 2, 1'b0);

    for (int j = 0; j < 6; j++) begin
      int num, mode;
      bit reuse;
      num   = $urandom_range(0, 6);
      reuse = 1'($urandom_range(0, 1));
      mode  = $urandom_range(0, 2);
      if (reuse && num == 0) num = 1;
      run_job(num, reuse, mode, 1'b0);
    end

    chk("scoreboard_drained", q_addr.size() + q_row.size() + q_out.size() + q_num.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
